// File: rtl/dac_sample_buffer.sv
// dac_sample_buffer
//
// This block sits between the three-band EQ and the I2S transmitter.
// Each EQ sample is scaled by a soft-mute gain g before it is stored.
// g runs from 0 to 256, where 256 is unity. The gain ramps up or down
// by STEP for each accepted sample, so mute and start-up do not pop.
// Scaled samples wait in a DEPTH-entry FIFO. On each TX request the
// head sample is returned as the packed word {8'h00, sample, 8'h00}.
//
// Ports:
//   lmmi_clk_i   system clock
//   reset_n_i    asynchronous active-low reset
//   s_valid_i    one-cycle strobe; s_data_i carries a new sample
//   s_data_i     signed 16-bit EQ sample
//   mute_i       level-sensitive soft-mute request
//   dac_req_i    one-cycle sample request from the I2S TX
//   clr_flags_i  synchronous clear of the sticky flags
//   dac_data_o   packed output word (silence when the FIFO is empty)
//   level_o      FIFO occupancy
//   muted_o      high while the gain FSM is in MUTED
//   overflow_o   sticky: a sample was dropped because the FIFO was full
//   underflow_o  sticky: a request arrived while the FIFO was empty
//
// Gain FSM states:
//   state       | meaning
//   S_MUTED     | g = 0, waiting for mute_i to drop
//   S_RAMP_UP   | g rising by STEP per accepted sample
//   S_UNMUTED   | g = 256 (unity), waiting for mute_i
//   S_RAMP_DOWN | g falling by STEP per accepted sample

module dac_sample_buffer #(
    parameter int DEPTH = 4,
    parameter int STEP  = 8
) (
    input  logic                     lmmi_clk_i,
    input  logic                     reset_n_i,
    input  logic                     s_valid_i,
    input  logic [15:0]              s_data_i,
    input  logic                     mute_i,
    input  logic                     dac_req_i,
    input  logic                     clr_flags_i,
    output logic [31:0]              dac_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     muted_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [9:0] STEP_W = 10'(STEP);
    localparam logic [9:0] UNITY  = 10'd256;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_MUTED,
        S_RAMP_UP,
        S_UNMUTED,
        S_RAMP_DOWN
    } state_t;

    state_t state_q, state_d;
    logic [8:0] g_q, g_d;

    // Saturating gain steps, computed in 10 bits so g + STEP cannot wrap.
    logic [9:0] g_ext, g_inc, g_up, g_dn;

    assign g_ext = {1'b0, g_q};
    assign g_inc = g_ext + STEP_W;
    assign g_up  = (g_inc >= UNITY) ? UNITY : g_inc;
    assign g_dn  = (g_ext <= STEP_W) ? 10'd0 : (g_ext - STEP_W);

    // Leaving MUTED or UNMUTED applies the first ramp step on that same
    // sample, so a complete ramp takes exactly ceil(256/STEP) samples.
    // A reversal in the middle of a ramp holds g for one sample.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        if (s_valid_i) begin
            case (state_q)
                S_MUTED: begin
                    if (!mute_i) begin
                        g_d     = 9'(g_up);
                        state_d = (g_up == UNITY) ? S_UNMUTED : S_RAMP_UP;
                    end
                end
                S_RAMP_UP: begin
                    if (mute_i) begin
                        state_d = S_RAMP_DOWN;
                    end else begin
                        g_d = 9'(g_up);
                        if (g_up == UNITY) state_d = S_UNMUTED;
                    end
                end
                S_UNMUTED: begin
                    if (mute_i) begin
                        g_d     = 9'(g_dn);
                        state_d = (g_dn == 10'd0) ? S_MUTED : S_RAMP_DOWN;
                    end
                end
                S_RAMP_DOWN: begin
                    if (!mute_i) begin
                        state_d = S_RAMP_UP;
                    end else begin
                        g_d = 9'(g_dn);
                        if (g_dn == 10'd0) state_d = S_MUTED;
                    end
                end
                default: begin
                    state_d = S_MUTED;
                    g_d     = 9'd0;
                end
            endcase
        end
    end

    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_MUTED;
            g_q     <= 9'd0;
            muted_o <= 1'b1;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            muted_o <= (state_d == S_MUTED);
        end
    end

    // The product fits in 25 bits because g <= 256. Shifting it right by
    // 8 and keeping 16 bits gives truncation toward minus infinity.
    // The current g_q is used, so each sample sees the gain in effect
    // before that sample's ramp step.
    logic signed [25:0] data_ext, gain_ext, prod;
    logic        [15:0] scaled;

    assign data_ext = 26'($signed(s_data_i));
    assign gain_ext = {17'd0, g_q};
    assign prod     = data_ext * gain_ext;
    assign scaled   = 16'(prod >>> 8);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    assign full  = (level_o == FULL_LVL);
    assign empty = (level_o == '0);
    assign pop   = dac_req_i && !empty;
    // A full FIFO still accepts a sample when a pop happens in the same
    // cycle. An empty FIFO never bypasses: the new sample is only stored.
    assign push  = s_valid_i && (!full || pop);

    always_ff @(posedge lmmi_clk_i) begin
        if (push) mem[wr_ptr] <= scaled;
    end

    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_o     <= '0;
            dac_data_o  <= 32'h0000_0000;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   level_o <= level_o + 1'b1;
                2'b01:   level_o <= level_o - 1'b1;
                default: level_o <= level_o;
            endcase

            if (dac_req_i) begin
                dac_data_o <= empty ? 32'h0000_0000 : {8'h00, mem[rd_ptr], 8'h00};
            end

            // A new error in the same cycle as clr_flags_i keeps its flag set.
            if (s_valid_i && full && !dac_req_i) overflow_o <= 1'b1;
            else if (clr_flags_i)                overflow_o <= 1'b0;

            if (dac_req_i && empty)  underflow_o <= 1'b1;
            else if (clr_flags_i)    underflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_sample_buffer.sv
module tb_dac_sample_buffer;

    logic        lmmi_clk_i = 1'b0;
    logic        reset_n_i  = 1'b0;
    logic        s_valid_i  = 1'b0;
    logic [15:0] s_data_i   = 16'h0000;
    logic        mute_i     = 1'b0;
    logic        dac_req_i  = 1'b0;
    logic        clr_flags_i = 1'b0;
    logic [31:0] dac_data_o;
    logic [2:0]  level_o;
    logic        muted_o, overflow_o, underflow_o;

    int checks = 0;
    int errors = 0;

    dac_sample_buffer #(.DEPTH(4), .STEP(8)) dut (
        .lmmi_clk_i  (lmmi_clk_i),
        .reset_n_i   (reset_n_i),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .mute_i      (mute_i),
        .dac_req_i   (dac_req_i),
        .clr_flags_i (clr_flags_i),
        .dac_data_o  (dac_data_o),
        .level_o     (level_o),
        .muted_o     (muted_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 lmmi_clk_i = ~lmmi_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later.
    task automatic cyc(input logic v, input logic [15:0] d, input logic m,
                       input logic r, input logic c);
        s_valid_i   = v;
        s_data_i    = d;
        mute_i      = m;
        dac_req_i   = r;
        clr_flags_i = c;
        @(posedge lmmi_clk_i);
        #1;
        s_valid_i   = 1'b0;
        dac_req_i   = 1'b0;
        clr_flags_i = 1'b0;
    endtask

    function automatic logic [31:0] pack(input int s);
        logic [15:0] v;
        v = 16'(s);
        return {8'h00, v, 8'h00};
    endfunction

    // Expected output for input 0x4000 at gain g is 0x4000*g/256 = 64*g.
    function automatic int at_half(input int g);
        return 64 * g;
    endfunction

    initial begin
        #12;
        check("rst_data",  dac_data_o, 32'h0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_ovf",   32'(overflow_o), 32'd0);
        check("rst_udf",   32'(underflow_o), 32'd0);
        check("rst_muted", 32'(muted_o), 32'd1);
        reset_n_i = 1'b1;
        @(posedge lmmi_clk_i);
        #1;

        // Start-up ramp: sample i is scaled by min(8*i, 256).
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
            if (i == 0) check("ramp_muted_low", 32'(muted_o), 32'd0);
            cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
            check($sformatf("ramp_up_%0d", i), dac_data_o,
                  pack(at_half((8 * i > 256) ? 256 : 8 * i)));
        end
        check("ramp_level", 32'(level_o), 32'd0);

        // Most negative input at unity gain.
        cyc(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("neg_unity", dac_data_o, 32'h0080_0000);

        // Mute ramp from unity: sample j is scaled by 256 - 8*j.
        for (int j = 0; j < 32; j++) begin
            cyc(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0);
            check($sformatf("mute_flag_%0d", j), 32'(muted_o), (j == 31) ? 32'd1 : 32'd0);
            cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
            check($sformatf("ramp_dn_%0d", j), dac_data_o, pack(at_half(256 - 8 * j)));
        end

        // Unmute and climb to g = 128.
        for (int j = 0; j < 16; j++) begin
            cyc(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
            check($sformatf("reup_%0d", j), dac_data_o, pack(at_half(8 * j)));
        end
        // Reverse at g = 128: -32768 * 128 / 256 = -16384.
        cyc(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("neg_half", dac_data_o, 32'h00C0_0000);
        cyc(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("rev_dn_hold", dac_data_o, 32'h0020_0000);
        // Reverse again at g = 120: held for one sample, then it rises.
        cyc(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("rev_up_hold", dac_data_o, 32'h001E_0000);
        cyc(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("rev_up_same", dac_data_o, 32'h001E_0000);
        cyc(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("rev_up_rise", dac_data_o, 32'h0020_0000);
        // From g = 136 back to unity (15 more steps).
        for (int k = 0; k < 15; k++) begin
            cyc(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
            check($sformatf("back_up_%0d", k), dac_data_o, pack(at_half(136 + 8 * k)));
        end

        // Overflow: five strobes, no requests.
        cyc(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
        check("fill_level", 32'(level_o), 32'd4);
        check("fill_no_ovf", 32'(overflow_o), 32'd0);
        cyc(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
        check("ovf_level", 32'(level_o), 32'd4);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("ovf_pop0", dac_data_o, 32'h0011_1100);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("ovf_pop1", dac_data_o, 32'h0022_2200);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("ovf_pop2", dac_data_o, 32'h0033_3300);
        check("ovf_pop_level", 32'(level_o), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("ovf_pop3", dac_data_o, 32'h0044_4400);
        check("ovf_no_udf", 32'(underflow_o), 32'd0);

        // Underflow on empty; then a simultaneous strobe and request.
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("udf_data", dac_data_o, 32'h0);
        check("udf_flag", 32'(underflow_o), 32'd1);
        cyc(1'b1, 16'h0100, 1'b0, 1'b1, 1'b0);
        check("udf_wr_level", 32'(level_o), 32'd1);
        check("udf_wr_data", dac_data_o, 32'h0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("clr_udf", 32'(underflow_o), 32'd0);
        check("clr_ovf", 32'(overflow_o), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("no_bypass_pop", dac_data_o, 32'h0001_0000);
        // Set wins over clear.
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        check("set_wins", 32'(underflow_o), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("clr_again", 32'(underflow_o), 32'd0);

        // Full FIFO with simultaneous strobe and request.
        cyc(1'b1, 16'hA001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hA002, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hA003, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hA004, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hA005, 1'b0, 1'b1, 1'b0);
        check("full_rw_level", 32'(level_o), 32'd4);
        check("full_rw_ovf", 32'(overflow_o), 32'd0);
        check("full_rw_data", dac_data_o, 32'h00A0_0100);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("full_rw_next", dac_data_o, 32'h00A0_0200);

        // Asynchronous reset in the middle of a cycle.
        #2;
        reset_n_i = 1'b0;
        #1;
        check("arst_data",  dac_data_o, 32'h0);
        check("arst_level", 32'(level_o), 32'd0);
        check("arst_muted", 32'(muted_o), 32'd1);
        check("arst_ovf",   32'(overflow_o), 32'd0);
        check("arst_udf",   32'(underflow_o), 32'd0);
        #10;
        reset_n_i = 1'b1;
        @(posedge lmmi_clk_i);
        #1;
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("post_rst_udf", 32'(underflow_o), 32'd1);
        check("post_rst_empty", 32'(level_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
